// File: rtl/ultrasonic_ranger_if.sv
// Pin/result bundle between the ultrasonic ranger and its sensor/consumer side.
// The slave modport is the ranger itself; the master modport is whoever drives the requests and echo.
interface ultrasonic_ranger_if #(
    parameter int DATA_W = 9
);
    logic              start;
    logic              continuous;
    logic              echo;
    logic              trig;
    logic              busy;
    logic              valid;
    logic              timeout;
    logic [DATA_W-1:0] data;

    modport master (
        output start, continuous, echo,
        input  trig, busy, valid, timeout, data
    );

    modport slave (
        input  start, continuous, echo,
        output trig, busy, valid, timeout, data
    );
endinterface

// File: rtl/ultrasonic_ranger.sv
// Pulse-echo ultrasonic ranging controller: trigger, echo-width measurement in us,
// on-the-fly conversion to cm, timeout detection and single/continuous operation.
module ultrasonic_ranger #(
    parameter int CLKS_PER_US = 50,
    parameter int TRIG_US     = 10,
    parameter int US_PER_CM   = 58,
    parameter int MAX_US      = 30000,
    parameter int HOLDOFF_US  = 60000,
    parameter int DATA_W      = 9
) (
    input  logic                clk,
    input  logic                reset,
    ultrasonic_ranger_if.slave  bus
);
    localparam int MAX_A   = (MAX_US > HOLDOFF_US) ? MAX_US : HOLDOFF_US;
    localparam int MAX_ALL = (MAX_A > TRIG_US) ? MAX_A : TRIG_US;
    localparam int US_W    = $clog2(MAX_ALL + 1);
    localparam int PRE_W   = $clog2(CLKS_PER_US);
    localparam int SUB_W   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [US_W-1:0]   us_q, us_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DATA_W-1:0] cm_q, cm_d;
    logic              sync1_q, sync2_q, echo_prev_q;
    logic              trig_q, trig_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              have_result_q, have_result_d;

    logic us_tick;
    logic echo_rise;
    logic echo_fall;
    logic us_at_max;

    always_comb begin
        us_tick   = (pre_q == PRE_W'(CLKS_PER_US - 1));
        echo_rise = sync2_q & ~echo_prev_q;
        echo_fall = ~sync2_q & echo_prev_q;
        us_at_max = us_tick && (us_q == US_W'(MAX_US - 1));

        state_d       = state_q;
        data_d        = data_q;
        timeout_d     = timeout_q;
        valid_d       = 1'b0;
        have_result_d = have_result_q;

        // cm_d includes the tick landing in the current cycle, so a fall seen here reports it
        sub_d = sub_q;
        cm_d  = cm_q;
        if (state_q == MEASURE && us_tick) begin
            if (sub_q == SUB_W'(US_PER_CM - 1)) begin
                sub_d = '0;
                if (cm_q != '1) begin
                    cm_d = cm_q + DATA_W'(1);
                end
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start || (bus.continuous && have_result_q)) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (us_tick && us_q == US_W'(TRIG_US - 1)) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                end else if (us_at_max) begin
                    state_d       = HOLDOFF;
                    data_d        = '1;
                    timeout_d     = 1'b1;
                    valid_d       = 1'b1;
                    have_result_d = 1'b1;
                end
            end
            MEASURE: begin
                // A fall coinciding with the limit still counts as a good echo
                if (echo_fall) begin
                    state_d       = HOLDOFF;
                    data_d        = cm_d;
                    timeout_d     = 1'b0;
                    valid_d       = 1'b1;
                    have_result_d = 1'b1;
                end else if (us_at_max) begin
                    state_d       = HOLDOFF;
                    data_d        = '1;
                    timeout_d     = 1'b1;
                    valid_d       = 1'b1;
                    have_result_d = 1'b1;
                end
            end
            HOLDOFF: begin
                if (us_tick && us_q == US_W'(HOLDOFF_US - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || state_q == IDLE) begin
            pre_d = '0;
            us_d  = '0;
            sub_d = '0;
            cm_d  = '0;
        end else begin
            pre_d = us_tick ? '0 : pre_q + PRE_W'(1);
            us_d  = us_tick ? us_q + US_W'(1) : us_q;
        end

        trig_d = (state_d == TRIG);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pre_q         <= '0;
            us_q          <= '0;
            sub_q         <= '0;
            cm_q          <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            echo_prev_q   <= 1'b0;
            trig_q        <= 1'b0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
            data_q        <= '0;
            have_result_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            us_q          <= us_d;
            sub_q         <= sub_d;
            cm_q          <= cm_d;
            sync1_q       <= bus.echo;
            sync2_q       <= sync1_q;
            echo_prev_q   <= sync2_q;
            trig_q        <= trig_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
            data_q        <= data_d;
            have_result_q <= have_result_d;
        end
    end

    assign bus.trig    = trig_q;
    assign bus.busy    = busy_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
    assign bus.data    = data_q;
endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
Parametrised controller for a pulse-echo ultrasonic distance sensor. It generates the trigger pulse, measures echo width in microseconds, and converts the width to centimetres on the fly. It also detects missing or stuck echoes and supports single-shot and continuous ranging. It sits between the sensor pins and display/consumer logic and presents one registered result with a valid strobe.

Parameters:
CLKS_PER_US, 50, clk cycles per microsecond tick (>=2)
TRIG_US, 10, trigger pulse width in us
US_PER_CM, 58, echo microseconds per centimetre
MAX_US, 30000, timeout limit in us for both echo-rise wait and echo-high measurement
HOLDOFF_US, 60000, dead time in us after each result before the next trigger
DATA_W, 9, width of the distance result

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin one measurement; honoured only in IDLE
continuous  input  1  1 = re-trigger automatically after holdoff; sampled in IDLE
echo  input  1  sensor echo, asynchronous; passed through a 2-flop synchroniser
trig  output  1  sensor trigger pulse
busy  output  1  high in every state except IDLE
valid  output  1  one-cycle strobe when data/timeout update
timeout  output  1  1 = last result aborted (no rise or stuck high)
data  output  DATA_W  last distance in cm

Behaviour:
- Reset (async): state=IDLE; trig=0, busy=0, valid=0, timeout=0, data=0; all counters and synchroniser flops=0.
- Prescaler: counts 0..CLKS_PER_US-1; us_tick when it equals CLKS_PER_US-1. It is cleared on every state entry, so each state's us count starts phase-aligned.
- us counter: wide enough for max(MAX_US, HOLDOFF_US, TRIG_US). Cleared on state entry; increments on us_tick.
- cm sub-counter: 0..US_PER_CM-1 on us_tick in MEASURE. On wrap, cm increments, saturating at 2^DATA_W-1.
- echo_s = 2nd synchroniser flop. Rise/fall are detected on echo_s against its previous value.
- IDLE: go to TRIG when start=1, or when continuous=1 and a prior result exists.
- TRIG: trig=1 for exactly TRIG_US*CLKS_PER_US cycles, starting the cycle after entry. Then go to WAIT_RISE.
- WAIT_RISE: on echo_s rise, go to MEASURE with us/cm cleared. If the us count reaches MAX_US first: data=all ones, timeout=1, valid pulse, go to HOLDOFF.
- MEASURE: on echo_s fall, data=cm count, which is floor(us/US_PER_CM) saturated; timeout=0, valid pulse, go to HOLDOFF. If the us count reaches MAX_US before the fall: data=all ones, timeout=1, valid pulse, go to HOLDOFF.
- HOLDOFF: wait HOLDOFF_US microseconds, then go to IDLE. In continuous mode the FSM re-enters TRIG from IDLE on the next cycle.
- data and timeout hold their value between results. valid is high for exactly one cycle, coincident with the update.
- start while busy: ignored, not queued.
- Echo rise during TRIG: ignored. Only a rise seen in WAIT_RISE starts measurement.
- Fall and MAX_US in the same cycle: the fall wins, giving a normal result with timeout=0.
- continuous deasserted mid-cycle: the current measurement completes, then the FSM stays in IDLE.
- Reset mid-operation: immediate return to reset values; no valid is emitted.

Test Plan:
(Bench params: CLKS_PER_US=2, TRIG_US=3, US_PER_CM=4, MAX_US=80, HOLDOFF_US=5, DATA_W=4.)
1. Apply reset, release, idle 20 cycles -> trig=0, busy=0, valid=0, timeout=0, data=0 throughout.
2. start pulse; echo high for 46 cycles after trig falls -> trig high exactly 6 cycles; valid once; data=5 (23us/4); timeout=0; busy low 10 cycles after valid.
3. start; echo never rises -> valid exactly 160 cycles (80us) after entering WAIT_RISE; data=15, timeout=1. Echo held high 170us -> same abort from MEASURE.
4. start; echo high 70us -> cm saturates; data=15, timeout=0.
5. continuous=1, echo 40us per cycle; start pulsed again while busy -> back-to-back results data=10, separated by 5us holdoff plus trigger/wait. No extra measurement from the ignored start.
6. Assert reset midway through MEASURE, then release -> all outputs 0 immediately, no valid, FSM in IDLE. Next start measures correctly (data=5 for 23us).
